// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage with PC register, ICACHE miss FSM and IF/ID pipeline register
//
// Purpose:
//    Owns PCF and issues one fetch request per cycle to the ICACHE. A hit
//    (ic_ready in FETCH) delivers the word in the same cycle. A miss parks the
//    FSM in MISS with PCF held until the response arrives. A redirect during a
//    miss moves to DRAIN, which swallows the wrong-path response before
//    refetching from the latest redirect target. Misses insert bubbles into D.
//
// Ports:
//    clk, rst_n            rising-edge clock, synchronous active-low reset
//    stallF, stallD        hold PCF / hold IF/ID register
//    flushD                squash IF/ID
//    pcsrcE, pctargetE     redirect request and target
//    ic_req, ic_addr       fetch request valid and address (ic_addr = PCF)
//    ic_ready, ic_rdata    response valid and instruction word
//    instrD, pcD, pcplus4D IF/ID register contents
//    validD                instrD is a real instruction
//    fetch_busy            miss outstanding (MISS or DRAIN)
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//    perf_fetched          instructions loaded into IF/ID with validD=1
//    perf_miss_cyc         cycles spent in MISS or DRAIN
//    perf_redirect         cycles with pcsrcE=1

module fetch_stage #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stallF,
   input  logic            stallD,
   input  logic            flushD,
   input  logic            pcsrcE,
   input  logic [XLEN-1:0] pctargetE,
   output logic            ic_req,
   output logic [XLEN-1:0] ic_addr,
   input  logic            ic_ready,
   input  logic [31:0]     ic_rdata,
   output logic [31:0]     instrD,
   output logic [XLEN-1:0] pcD,
   output logic [XLEN-1:0] pcplus4D,
   output logic            validD,
   output logic            fetch_busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_miss_cyc,
   output logic [31:0]     perf_redirect
`endif
);

   typedef enum logic [1:0] {S_FETCH, S_MISS, S_DRAIN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pcf;
   logic [XLEN-1:0] r_pend_tgt;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_pcd;
   logic [XLEN-1:0] r_pcp4d;
   logic            r_valid;
   logic            w_resp;
   logic            w_take;
   logic [XLEN-1:0] w_pcf_p4;

   assign w_pcf_p4 = r_pcf + XLEN'(4);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: if (!ic_ready && !pcsrcE) w_state_nxt = S_MISS;
         S_MISS: begin
            if (ic_ready)    w_state_nxt = S_FETCH;
            else if (pcsrcE) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: if (ic_ready) w_state_nxt = S_FETCH;
         default: w_state_nxt = S_FETCH;
      endcase
   end

   // Output logic. A response in DRAIN belongs to the wrong path and is never
   // usable; a usable word is only consumed when neither F nor D is stalled,
   // otherwise the next cycle re-requests the same (now filled) line.
   always_comb begin
      ic_req     = rst_n;
      fetch_busy = (r_state != S_FETCH);
      w_resp     = ic_ready && (r_state != S_DRAIN);
      w_take     = w_resp && !stallF && !stallD;
   end

   // PCF and pending redirect target. While a miss is open PCF must not move,
   // so a redirect is parked in r_pend_tgt (newest wins) until the stale
   // response drains. A redirect coinciding with the miss response needs no
   // drain since that response completes the request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pcf      <= RESET_PC;
         r_pend_tgt <= '0;
      end else begin
         case (r_state)
            S_DRAIN: begin
               if (pcsrcE) r_pend_tgt <= pctargetE;
               if (ic_ready) r_pcf <= pcsrcE ? pctargetE : r_pend_tgt;
            end
            S_MISS: begin
               if (pcsrcE) begin
                  if (ic_ready) r_pcf      <= pctargetE;
                  else          r_pend_tgt <= pctargetE;
               end else if (w_take) begin
                  r_pcf <= w_pcf_p4;
               end
            end
            default: begin
               if (pcsrcE)      r_pcf <= pctargetE;
               else if (w_take) r_pcf <= w_pcf_p4;
            end
         endcase
      end
   end

   // IF/ID register; bubbles keep the previous pcD/pcplus4D.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_instr <= NOP_INSTR;
         r_pcd   <= '0;
         r_pcp4d <= '0;
         r_valid <= 1'b0;
      end else if (flushD || pcsrcE) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (stallD) begin
         r_instr <= r_instr;
      end else if (w_take) begin
         r_instr <= ic_rdata;
         r_pcd   <= r_pcf;
         r_pcp4d <= w_pcf_p4;
         r_valid <= 1'b1;
      end else begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end
   end

   assign ic_addr  = r_pcf;
   assign instrD   = r_instr;
   assign pcD      = r_pcd;
   assign pcplus4D = r_pcp4d;
   assign validD   = r_valid;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_miss_cyc;
   logic [31:0] r_perf_redirect;
   logic        w_load_valid;

   // Mirrors the IF/ID load branch: a real instruction enters D.
   assign w_load_valid = w_take && !flushD && !pcsrcE && !stallD;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_fetched  <= '0;
         r_perf_miss_cyc <= '0;
         r_perf_redirect <= '0;
      end else begin
         if (w_load_valid) r_perf_fetched  <= r_perf_fetched + 32'd1;
         if (fetch_busy)   r_perf_miss_cyc <= r_perf_miss_cyc + 32'd1;
         if (pcsrcE)       r_perf_redirect <= r_perf_redirect + 32'd1;
      end
   end

   assign perf_fetched  = r_perf_fetched;
   assign perf_miss_cyc = r_perf_miss_cyc;
   assign perf_redirect = r_perf_redirect;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with a behavioural reference model
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, pcsrcE = 1'b0;
   logic [31:0] pctargetE = '0;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_ready = 1'b0;
   logic [31:0] ic_rdata;
   logic [31:0] instrD, pcD, pcplus4D;
   logic        validD, fetch_busy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_miss_cyc, perf_redirect;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state: PC, whether a miss is open, whether it is a wrong-path
   // miss awaiting its response, the redirect to apply afterwards, and D.
   logic [31:0] m_pc, m_pend, m_instr, m_pcd, m_p4d;
   bit          m_open, m_wrong, m_valid;
   logic [31:0] m_fetched, m_misscyc, m_redir;

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0F0F_5A5A;
   endfunction

   assign ic_rdata = ic_ready ? instr_of(ic_addr) : 32'hDEAD_BEEF;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
      .pcsrcE(pcsrcE), .pctargetE(pctargetE), .ic_req(ic_req), .ic_addr(ic_addr),
      .ic_ready(ic_ready), .ic_rdata(ic_rdata), .instrD(instrD), .pcD(pcD),
      .pcplus4D(pcplus4D), .validD(validD), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_miss_cyc(perf_miss_cyc), .perf_redirect(perf_redirect)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive inputs, advance the model, then compare every output.
   task automatic step(input bit rst, input bit r, input bit sf, input bit sd,
                       input bit fd, input bit pcs, input logic [31:0] tgt);
      logic [31:0] n_pc, n_pend, n_instr, n_pcd, n_p4d;
      bit          n_open, n_wrong, n_valid, usable, take;
      rst_n = rst; ic_ready = r; stallF = sf; stallD = sd;
      flushD = fd; pcsrcE = pcs; pctargetE = tgt;

      n_pc = m_pc; n_pend = m_pend; n_open = m_open; n_wrong = m_wrong;
      n_instr = m_instr; n_pcd = m_pcd; n_p4d = m_p4d; n_valid = m_valid;
      if (!rst) begin
         n_pc = 32'h0; n_pend = 32'h0; n_open = 0; n_wrong = 0;
         n_instr = NOP; n_pcd = 0; n_p4d = 0; n_valid = 0;
         m_fetched = 0; m_misscyc = 0; m_redir = 0;
      end else begin
         usable = r && !m_wrong;
         take   = usable && !sf && !sd;
         if (m_open || m_wrong) m_misscyc++;
         if (pcs) m_redir++;
         if (fd || pcs) begin
            n_instr = NOP; n_valid = 0;
         end else if (sd) begin
            // hold
         end else if (take) begin
            n_instr = instr_of(m_pc); n_pcd = m_pc; n_p4d = m_pc + 4; n_valid = 1;
            m_fetched++;
         end else begin
            n_instr = NOP; n_valid = 0;
         end
         if (m_wrong) begin
            if (pcs) n_pend = tgt;
            if (r) begin n_pc = pcs ? tgt : m_pend; n_wrong = 0; end
         end else if (m_open) begin
            if (r) begin
               n_open = 0;
               if (pcs) n_pc = tgt; else if (take) n_pc = m_pc + 4;
            end else if (pcs) begin
               n_open = 0; n_wrong = 1; n_pend = tgt;
            end
         end else begin
            if (pcs) n_pc = tgt;
            else if (take) n_pc = m_pc + 4;
            else if (!r) n_open = 1;
         end
      end

      @(posedge clk); #1;
      m_pc = n_pc; m_pend = n_pend; m_open = n_open; m_wrong = n_wrong;
      m_instr = n_instr; m_pcd = n_pcd; m_p4d = n_p4d; m_valid = n_valid;

      check("ic_req", {31'd0, ic_req}, {31'd0, rst});
      check("ic_addr", ic_addr, m_pc);
      check("fetch_busy", {31'd0, fetch_busy}, {31'd0, (m_open || m_wrong)});
      check("instrD", instrD, m_instr);
      check("pcD", pcD, m_pcd);
      check("pcplus4D", pcplus4D, m_p4d);
      check("validD", {31'd0, validD}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_miss_cyc", perf_miss_cyc, m_misscyc);
      check("perf_redirect", perf_redirect, m_redir);
`endif
   endtask

   initial begin
      bit r, sf, sd, fd, pcs, rst;
      logic [31:0] tgt;

      // 1: reset then four hits
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0);
      check("rst_ic_req", {31'd0, ic_req}, 32'd0);
      check("rst_addr", ic_addr, 32'h0);
      check("rst_instr", instrD, NOP);
      for (int i = 0; i < 4; i++) begin
         step(1, 1, 0, 0, 0, 0, 0);
         check("t1_addr", ic_addr, 32'(4 * (i + 1)));
         check("t1_pcD", pcD, 32'(4 * i));
         check("t1_valid", {31'd0, validD}, 32'd1);
      end

      // 2: miss at 0x10 for three cycles
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 0, 0);
         check("t2_addr", ic_addr, 32'h10);
         check("t2_busy", {31'd0, fetch_busy}, 32'd1);
         check("t2_valid", {31'd0, validD}, 32'd0);
      end
      step(1, 1, 0, 0, 0, 0, 0);
      check("t2_instr", instrD, instr_of(32'h10));
      check("t2_pcD", pcD, 32'h10);
      check("t2_next", ic_addr, 32'h14);

      // 3: redirect while missing at 0x20
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 1, 32'h100);
      check("t3_busy", {31'd0, fetch_busy}, 32'd1);
      check("t3_held", ic_addr, 32'h20);
      step(1, 1, 0, 0, 0, 0, 0);
      check("t3_addr", ic_addr, 32'h100);
      check("t3_valid", {31'd0, validD}, 32'd0);

      // 4: stalled hit at 0x30, then release
      step(1, 1, 0, 0, 1, 1, 32'h30);
      step(1, 1, 1, 1, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0, 0);
      check("t4_addr", ic_addr, 32'h30);
      check("t4_instr", instrD, NOP);
      step(1, 1, 0, 0, 0, 0, 0);
      check("t4_pcD", pcD, 32'h30);
      step(1, 1, 0, 0, 0, 0, 0);
      check("t4_pcD2", pcD, 32'h34);

      // 5: redirect overrides stallF
      step(1, 1, 1, 0, 1, 1, 32'h200);
      check("t5_addr", ic_addr, 32'h200);
      check("t5_valid", {31'd0, validD}, 32'd0);

      // 6: reset in MISS
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t6_busy", {31'd0, fetch_busy}, 32'd0);
      check("t6_addr", ic_addr, 32'h0);
      check("t6_req", {31'd0, ic_req}, 32'd0);
      step(1, 1, 0, 0, 0, 0, 0);

      // PC wrap at the top of the address space
      step(1, 1, 0, 0, 1, 1, 32'hFFFF_FFF8);
      step(1, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0);
      check("wrap_addr", ic_addr, 32'h0);
      check("wrap_p4", pcplus4D, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) != 0);
         r   = ($urandom_range(0, 2) != 0);
         sf  = ($urandom_range(0, 5) == 0);
         sd  = ($urandom_range(0, 5) == 0);
         pcs = ($urandom_range(0, 7) == 0);
         if ((m_open || m_wrong) && r) pcs = 0;
         fd  = pcs || ($urandom_range(0, 15) == 0);
         tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : {$urandom, 2'b00} >> 0;
         tgt[1:0] = 2'b00;
         step(rst, r, sf, sd, fd, pcs, tgt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
